fireboy_direction_sequencer: RTL

Per-character sprite-direction controller that drives the 4-bit direction select consumed by color_mapper (Fireboy_direction; a second instance drives Watergirl_direction).
Samples movement/velocity flags once per video frame and produces a debounced 3x3 direction code (0..8, lu..rd) plus an animation phase counter.
Sits between the character motion logic and color_mapper, in the Clk domain, using frame_clk (VSYNC) as the frame strobe.

---
 rtl/dir_pkg.sv | 32 +++
 rtl/frame_edge_sync.sv | 37 +++
 rtl/fireboy_direction_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dir_pkg.sv
// dir_pkg: shared sprite-direction encoding for the frame-rate sprite blocks
// and color_mapper's direction case.
//
// The direction code is a 3x3 grid laid out as (3 * row + col):
//   row 0 = rising, 1 = level, 2 = falling
//   col 0 = left,   1 = none,  2 = right
// Codes 9..15 are never produced.
package dir_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_LU    = 4'd0;
  localparam dir_t DIR_UP    = 4'd1;
  localparam dir_t DIR_RU    = 4'd2;
  localparam dir_t DIR_LEFT  = 4'd3;
  localparam dir_t DIR_STILL = 4'd4;
  localparam dir_t DIR_RIGHT = 4'd5;
  localparam dir_t DIR_LD    = 4'd6;
  localparam dir_t DIR_DOWN  = 4'd7;
  localparam dir_t DIR_RD    = 4'd8;

  // Conflicting or absent intent on an axis collapses to the centre column/row.
  function automatic dir_t raw_dir(input logic left, input logic right,
                                   input logic up, input logic down);
    logic [3:0] col;
    logic [3:0] row;
    col = (left && !right) ? 4'd0 : ((right && !left) ? 4'd2 : 4'd1);
    row = (up && !down)    ? 4'd0 : ((down && !up)    ? 4'd2 : 4'd1);
    return dir_t'((row * 4'd3) + col);
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// frame_edge_sync: brings an asynchronous frame strobe (VSYNC) into the clk
// domain and emits a registered one-cycle pulse per rising edge.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   strobe     asynchronous frame strobe
//   tick       one-cycle pulse per synchronized 0->1 transition
//
// All flops reset to 1 (tick to 0) so a strobe that is already high at reset
// release does not count as an edge.
module frame_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic tick
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      tick      <= 1'b0;
    end else begin
      sync_1    <= strobe;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      tick      <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/fireboy_direction_sequencer.sv
// fireboy_direction_sequencer: per-character sprite-direction controller.
// Once per frame it samples the movement/velocity flags, debounces the raw
// 3x3 direction (a new value must persist HOLD_FRAMES ticks before it is
// committed) and advances an animation phase while the character is moving.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high
//   frame_clk    asynchronous VSYNC-derived frame strobe
//   enable       1 = process frame ticks, 0 = freeze all state
//   move_left    horizontal intent left
//   move_right   horizontal intent right
//   vy_up        character rising
//   vy_down      character falling
//   direction    committed direction code (dir_pkg encoding)
//   anim_phase   animation phase 0..ANIM_LEN-1
//   dir_changed  one-cycle pulse after a new direction is committed
//   frame_tick   one-cycle pulse per frame_clk rising edge
//
// All outputs are registered.
module fireboy_direction_sequencer
  import dir_pkg::*;
#(
  parameter int HOLD_FRAMES = 2,
  parameter int ANIM_DIV    = 4,
  parameter int ANIM_LEN    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       vy_up,
  input  logic       vy_down,
  output logic [3:0] direction,
  output logic [1:0] anim_phase,
  output logic       dir_changed,
  output logic       frame_tick
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_FRAMES);
  localparam logic [3:0] DIV_LAST = 4'(ANIM_DIV - 1);
  localparam logic [1:0] PH_LAST  = 2'(ANIM_LEN - 1);

  dir_t       dir_q,     dir_d;
  dir_t       cand_q,    cand_d;
  logic [3:0] cnt_q,     cnt_d;
  logic [3:0] div_q,     div_d;
  logic [1:0] phase_q,   phase_d;
  logic       changed_q, changed_d;

  dir_t       raw;
  logic [3:0] cnt_new;
  logic       commit;

  frame_edge_sync u_frame_edge_sync (
    .clk    (Clk),
    .reset  (Reset),
    .strobe (frame_clk),
    .tick   (frame_tick)
  );

  assign raw = raw_dir(move_left, move_right, vy_up, vy_down);

  always_comb begin
    dir_d     = dir_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    phase_d   = phase_q;
    changed_d = 1'b0;
    cnt_new   = 4'd0;
    commit    = 1'b0;

    if (frame_tick && enable) begin
      // Debounce: a differing raw code must repeat to build up the count.
      if (raw == dir_q) begin
        cnt_d  = 4'd0;
        cand_d = raw;
      end else begin
        if (raw != cand_q) cnt_new = 4'd1;
        else               cnt_new = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
        cand_d = raw;
        if (cnt_new >= HOLD_LIM) begin
          commit    = 1'b1;
          dir_d     = raw;
          cnt_d     = 4'd0;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_new;
        end
      end

      // Animation restarts on a new direction and idles while still.
      if (commit || dir_q == DIR_STILL) begin
        div_d   = 4'd0;
        phase_d = 2'd0;
      end else if (div_q == DIV_LAST) begin
        div_d   = 4'd0;
        phase_d = (phase_q == PH_LAST) ? 2'd0 : phase_q + 2'd1;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_q     <= DIR_STILL;
      cand_q    <= DIR_STILL;
      cnt_q     <= 4'd0;
      div_q     <= 4'd0;
      phase_q   <= 2'd0;
      changed_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      changed_q <= changed_d;
    end
  end

  assign direction   = dir_q;
  assign anim_phase  = phase_q;
  assign dir_changed = changed_q;

endmodule
